result_pack_stage: RTL

- Final FPU pipeline stage, directly downstream of the result-select control logic.
- Consumes the four final select fields plus the raw sign, exponent and fraction of the result, and assembles the IEEE-754 single-precision word.
- Classifies the assembled word and delivers it through a valid/ready output with a 2-entry skid buffer, so back-pressure never drops a result.
- Also accumulates sticky class flags that software clears explicitly.

---
 rtl/result_pack_stage.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/result_pack_stage.sv
// rtl/result_pack_stage.sv - FPU result packing, classification and valid/ready output stage
// Select encodings live in small packages so upstream control logic can share them.
package sign;
    typedef enum logic [1:0] {RESULT = 2'd0, ZERO = 2'd1, ONE = 2'd2} sign_select;
endpackage

package exponent;
    typedef enum logic [1:0] {RESULT = 2'd0, ONES = 2'd1, ZEROS = 2'd2} exponent_select;
endpackage

package fraction_msb;
    typedef enum logic [1:0] {RESULT = 2'd0, ZERO = 2'd1, ONE = 2'd2} fraction_msb_select;
endpackage

package fraction_lsbs;
    typedef enum logic [1:0] {RESULT = 2'd0, ZEROS = 2'd1} fraction_lsbs_select;
endpackage

module result_pack_stage #(
    parameter bit SKID_EN = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  sign::sign_select                   sign_select,
    input  exponent::exponent_select           exponent_select,
    input  fraction_msb::fraction_msb_select   fraction_msb_select,
    input  fraction_lsbs::fraction_lsbs_select fraction_lsbs_select,
    input  logic                               result_sign,
    input  logic [9:0]                         result_exponent,
    input  logic [24:0]                        result_fraction,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [31:0]                        out_result,
    output logic [3:0]                         out_class,
    output logic [3:0]                         sticky_flags,
    input  logic                               flags_clear
);

    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic [31:0] main_result_q, skid_result_q;
    logic [3:0]  main_class_q, skid_class_q;
    logic [3:0]  sticky_q;

    logic        pk_sign;
    logic [7:0]  pk_exp;
    logic        pk_msb;
    logic [21:0] pk_lsbs;
    logic [31:0] pk_word;
    logic [3:0]  pk_class;
    logic        accept, deliver;
    logic        main_load, main_from_skid, skid_load;

    // Carry/hidden bits and the exponent overflow bits are produced upstream but never packed.
    logic unused_bits;
    assign unused_bits = ^{result_exponent[9:8], result_fraction[24:23]};

    always_comb begin
        pk_sign = 1'b0;
        pk_exp  = 8'h00;
        pk_msb  = 1'b0;
        pk_lsbs = 22'd0;
        case (sign_select)
            sign::RESULT: pk_sign = result_sign;
            sign::ONE:    pk_sign = 1'b1;
            default:      pk_sign = 1'b0;
        endcase
        case (exponent_select)
            exponent::RESULT: pk_exp = result_exponent[7:0];
            exponent::ONES:   pk_exp = 8'hFF;
            default:          pk_exp = 8'h00;
        endcase
        case (fraction_msb_select)
            fraction_msb::RESULT: pk_msb = result_fraction[22];
            fraction_msb::ONE:    pk_msb = 1'b1;
            default:              pk_msb = 1'b0;
        endcase
        case (fraction_lsbs_select)
            fraction_lsbs::RESULT: pk_lsbs = result_fraction[21:0];
            default:               pk_lsbs = 22'd0;
        endcase
    end

    assign pk_word  = {pk_sign, pk_exp, pk_msb, pk_lsbs};
    assign pk_class = {(pk_exp == 8'hFF) && ({pk_msb, pk_lsbs} != 23'd0),
                       (pk_exp == 8'hFF) && ({pk_msb, pk_lsbs} == 23'd0),
                       (pk_exp == 8'h00) && ({pk_msb, pk_lsbs} == 23'd0),
                       (pk_exp == 8'h00) && ({pk_msb, pk_lsbs} != 23'd0)};

    assign out_valid    = (state_q != ST_EMPTY);
    assign in_ready     = SKID_EN ? in_ready_q : (~out_valid | out_ready);
    assign accept       = in_valid & in_ready;
    assign deliver      = out_valid & out_ready;
    assign out_result   = main_result_q;
    assign out_class    = main_class_q;
    assign sticky_flags = sticky_q;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_load = 1'b1;
                    state_d   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && deliver) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                    state_d   = ST_TWO;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (deliver) begin
                    main_from_skid = 1'b1;
                    state_d        = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Registered ready: decided from where the buffer will be, not where it is.
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_EMPTY;
            in_ready_q    <= 1'b1;
            main_result_q <= 32'd0;
            main_class_q  <= 4'd0;
            skid_result_q <= 32'd0;
            skid_class_q  <= 4'd0;
            sticky_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            if (main_load) begin
                main_result_q <= pk_word;
                main_class_q  <= pk_class;
            end else if (main_from_skid) begin
                main_result_q <= skid_result_q;
                main_class_q  <= skid_class_q;
            end
            if (skid_load) begin
                skid_result_q <= pk_word;
                skid_class_q  <= pk_class;
            end
            if (flags_clear) begin
                sticky_q <= 4'd0;
            end else if (deliver) begin
                sticky_q <= sticky_q | main_class_q;
            end
        end
    end

endmodule
